spi_xfer_sched: RTL

SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

---
 rtl/spi_xfer_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_xfer_sched.sv
// Two-requester round-robin scheduler in front of a single SPI core.
// Sequences each transfer through load, run (with timeout), read-back and response.
module spi_xfer_sched #(
  parameter int TIMEOUT = 1023,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [DW-1:0] txdata0,
  input  logic [DW-1:0] txdata1,
  input  logic [3:0]    len0,
  input  logic [3:0]    len1,
  input  logic [1:0]    mode0,
  input  logic [1:0]    mode1,
  output logic [1:0]    ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          spi_en,
  output logic          spi_we,
  output logic          spi_oe,
  output logic          spi_cpol,
  output logic          spi_cpha,
  output logic [3:0]    spi_len,
  output logic [DW-1:0] spi_wdata,
  input  logic [DW-1:0] spi_rdata,
  input  logic          spi_busy,
  input  logic          spi_done
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, READ, RESP} state_t;

  localparam logic [9:0] RUN_LAST = 10'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [3:0]    len_q, len_d;
  logic [1:0]    mode_q, mode_d;
  logic [9:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Completion is taken from spi_done alone; busy is informational only.
  logic busy_unused;
  assign busy_unused = spi_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tx_q    <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tx_d    = tx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // Under contention the requester not served last wins.
          grant_d = (req == 2'b11) ? ~last_q : req[1];
          tx_d    = grant_d ? txdata1 : txdata0;
          len_d   = grant_d ? len1 : len0;
          mode_d  = grant_d ? mode1 : mode0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (spi_done) begin
          state_d = READ;
        end else if (cnt_q == RUN_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      READ: begin
        rdata_d = spi_rdata;
        state_d = RESP;
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi_en    = (state_q == LOAD) || (state_q == RUN);
  assign spi_we    = (state_q == LOAD);
  assign spi_oe    = (state_q == READ);
  assign spi_wdata = tx_q;
  assign spi_len   = len_q;
  assign spi_cpol  = mode_q[1];
  assign spi_cpha  = mode_q[0];
  assign ack       = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign err       = (state_q == RESP) && err_q;
  assign rdata     = rdata_q;

endmodule
